traffic_phase_scheduler: RTL

//  Timing/request scheduler for the 6-state traffic light control FSM (states A..F = 0..5).

---
 rtl/traffic_phase_scheduler.sv | 117 +++++++++++
 1 files changed

// File: rtl/traffic_phase_scheduler.sv
// Phase timer and pedestrian request latch for the six-phase traffic light FSM.
// It divides the clock into timer ticks, times each phase and pulses 'change' for one cycle to step the FSM.
module traffic_phase_scheduler #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int WALK_T    = 5,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int CNT_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req1,
  input  logic       ped_req2,
  output logic       change,
  output logic [2:0] phase,
  output logic       ped_wait1,
  output logic       ped_wait2,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST    = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);

  typedef enum logic [2:0] {
    PH_A = 3'd0,
    PH_B = 3'd1,
    PH_C = 3'd2,
    PH_D = 3'd3,
    PH_E = 3'd4,
    PH_F = 3'd5
  } phase_t;

  phase_t           phase_q, phase_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             change_q, change_d;
  logic             wait1_q, wait1_d;
  logic             wait2_q, wait2_d;
  logic             tick_w;
  logic             expire;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q   <= PH_A;
      presc_q   <= '0;
      elapsed_q <= '0;
      change_q  <= 1'b0;
      wait1_q   <= 1'b0;
      wait2_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
      change_q  <= change_d;
      wait1_q   <= wait1_d;
      wait2_q   <= wait2_d;
    end
  end

  // Expiry is suppressed while a change is already in flight, so change can never repeat back to back.
  always_comb begin
    tick_w = enable && !reset && (presc_q == PRE_LAST);
    expire = 1'b0;
    if (tick_w && !change_q) begin
      case (phase_q)
        PH_A, PH_D: expire = (elapsed_q == WALK_LAST);
        PH_C, PH_F: expire = (elapsed_q == YELLOW_LAST);
        PH_B:       expire = ((elapsed_q >= GMIN_LAST) && wait1_q) || (elapsed_q == GMAX_LAST);
        PH_E:       expire = ((elapsed_q >= GMIN_LAST) && wait2_q) || (elapsed_q == GMAX_LAST);
        default:    expire = 1'b0;
      endcase
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_A:    if (change_q) phase_d = PH_B;
      PH_B:    if (change_q) phase_d = PH_C;
      PH_C:    if (change_q) phase_d = PH_D;
      PH_D:    if (change_q) phase_d = PH_E;
      PH_E:    if (change_q) phase_d = PH_F;
      PH_F:    if (change_q) phase_d = PH_A;
      default: phase_d = PH_A;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if (enable) presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;

    elapsed_d = elapsed_q;
    if (change_q)                elapsed_d = '0;
    else if (tick_w && !expire)  elapsed_d = elapsed_q + 1'b1;

    change_d = expire;

    // A request is dropped while its walk phase is lit and on the edge that enters it.
    wait1_d = wait1_q | ped_req1;
    if ((phase_q == PH_D) || (phase_d == PH_D)) wait1_d = 1'b0;
    wait2_d = wait2_q | ped_req2;
    if ((phase_q == PH_A) || (phase_d == PH_A)) wait2_d = 1'b0;
  end

  assign change    = change_q;
  assign phase     = phase_q;
  assign ped_wait1 = wait1_q;
  assign ped_wait2 = wait2_q;
  assign tick      = tick_w;

endmodule
